condlogic_pipe: RTL and testbench
=================================

Name: condlogic_pipe

Overview:
Parametrised pipelined successor of the single-cycle conditional-execution unit. Evaluates the 4-bit condition field of the instruction in the Execute (E) stage against banked NZCV flags. Registers gated control and pending flag updates into a Memory (M) stage, commits the flags from M, and forwards pending M-stage flags back to E. Adds stall/flush support, flag banks (user/interrupt contexts), an MSR-style flag load and a saturating condition-fail counter.

Parameters:
BANK_W, 1, width of the bank index; number of flag banks NBANK = 2**BANK_W.
FWD_EN, 1, 1 = forward pending M-stage flags to E; 0 = E reads committed bank only (hazards are resolved by external stalls).
COUNT_W, 16, width of the condition-fail counter.

Ports:
CLK  in  1  clock, rising edge
RST  in  1  synchronous active-high reset
Valid  in  1  E-stage instruction valid
Stall  in  1  hold M-stage register and counter
Flush  in  1  kill the E-stage instruction (bubble into M)
PCS  in  1  instruction writes PC
RegW  in  1  instruction writes register file
MemW  in  1  instruction writes memory
NoWrite  in  1  suppress register write (CMP/TST class)
FlagW  in  2  [1] = update N,Z; [0] = update C,V
Cond  in  4  ARM condition field
ALUFlags  in  4  {N,Z,C,V} from the ALU
BankSel  in  BANK_W  flag bank used by the E instruction
FlagLoad  in  1  E instruction loads all four flags from FlagLoadData
FlagLoadData  in  4  {N,Z,C,V} load value
CondExE  out  1  combinational: condition passed and Valid
PCSrcM  out  1  registered PCS && CondEx
RegWriteM  out  1  registered RegW && CondEx && ~NoWrite
MemWriteM  out  1  registered MemW && CondEx
ValidM  out  1  M stage holds a valid instruction
FlagsOut  out  4  committed flags of bank BankSel
FailCount  out  COUNT_W  saturating count of condition-failed instructions

Behaviour:
- Condition decode (flags N,Z,C,V = [3:0]):
  - 0000 EQ Z; 0001 NE !Z; 0010 CS C; 0011 CC !C; 0100 MI N; 0101 PL !N; 0110 VS V; 0111 VC !V.
  - 1000 HI C&!Z; 1001 LS !C|Z; 1010 GE N==V; 1011 LT N!=V; 1100 GT !Z&(N==V); 1101 LE Z|(N!=V).
  - 1110 AL 1; 1111 treated as 1.
- Effective E flags:
  - Start from bank[BankSel].
  - If FWD_EN=1, and M holds a valid, CondEx-passed flag write to the same bank, override per group: NZ if the M group-1 write is set, CV if the M group-0 write is set.
- CondExE = Valid && cond(EffFlags).
- Flag write enables: group enables = FlagLoad ? 2'b11 : FlagW. Write data = FlagLoad ? FlagLoadData : ALUFlags.
- M register, updated at a rising edge:
  - RST: all M fields 0.
  - else Flush: bubble (all 0, ValidM=0).
  - else Stall: hold.
  - else: load gated controls, ValidM=Valid, pending write enables (group enables AND CondExE), data, bank.
- Commit: at a rising edge with !RST && !Stall, the M pending write is written to its bank, per group. Flush does not block commit of the instruction leaving M. Flush has priority over Stall for the M load; the commit still occurs when Flush && Stall.
- Latency: E decision to M outputs is 1 cycle; flags are architecturally visible in FlagsOut 2 edges after E.
- FailCount: increments at an edge when Valid && !CondExE && !Stall && !Flush; saturates at all-ones with no wrap.
- Reset: all banks 0000, FailCount 0, PCSrcM/RegWriteM/MemWriteM/ValidM 0. Reset mid-pipeline discards the pending M write with no commit.
- FlagsOut and CondExE are combinational from committed state and inputs; there is no combinational path from Stall/Flush to CondExE.

Test Plan:
- Reset, then EQ instruction with Valid=1 and bank0=0000 -> CondExE=0; next edge FailCount=1, ValidM=1, RegWriteM=0.
- Forwarding: cycle 0 CMP with FlagW=11, ALUFlags=0100, AL; cycle 1 BEQ (PCS=1, Cond=0000) -> CondExE=1 in cycle 1; PCSrcM=1 after the next edge. Repeat with FWD_EN=0 -> CondExE=0.
- Partial group: M writes FlagW=01 with C=1 while bank0=1000; E issues MI -> effective flags 1010, MI passes; CS passes.
- Stall 3 cycles with a pending write -> M outputs held, flags committed exactly once, FailCount frozen. Flush+Stall together -> ValidM=0 and the pending write is still committed.
- Banks: FlagLoad with data 1111 on BankSel=1 -> bank1=1111, bank0 unchanged; FlagsOut with BankSel=0 reads 0000.
- Saturation: COUNT_W=2, five failing instructions -> FailCount=3. Reset asserted with a pending M write -> banks=0000, no commit.

Source files
------------

// File: rtl/condlogic_pipe.sv
// condlogic_pipe: pipelined conditional-execution unit with banked NZCV flags, M-stage forwarding and a fail counter
//   CLK, RST            clock, synchronous active-high reset
//   Valid/Stall/Flush   E-stage valid, M-stage hold, E-stage kill
//   PCS/RegW/MemW/NoWrite, FlagW, Cond, ALUFlags   E-stage instruction controls and ALU flags
//   BankSel, FlagLoad, FlagLoadData               flag bank select and MSR-style flag load
//   CondExE             combinational condition pass for the E instruction
//   PCSrcM/RegWriteM/MemWriteM/ValidM             registered gated controls in M
//   FlagsOut            committed flags of bank BankSel
//   FailCount           saturating count of condition-failed instructions
module condlogic_pipe #(
    parameter int BANK_W  = 1,
    parameter int FWD_EN  = 1,
    parameter int COUNT_W = 16
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               Valid,
    input  logic               Stall,
    input  logic               Flush,
    input  logic               PCS,
    input  logic               RegW,
    input  logic               MemW,
    input  logic               NoWrite,
    input  logic [1:0]         FlagW,
    input  logic [3:0]         Cond,
    input  logic [3:0]         ALUFlags,
    input  logic [BANK_W-1:0]  BankSel,
    input  logic               FlagLoad,
    input  logic [3:0]         FlagLoadData,
    output logic               CondExE,
    output logic               PCSrcM,
    output logic               RegWriteM,
    output logic               MemWriteM,
    output logic               ValidM,
    output logic [3:0]         FlagsOut,
    output logic [COUNT_W-1:0] FailCount
);
    localparam int NBANK = 2 ** BANK_W;

    logic [3:0]         r_bank [NBANK];
    logic               r_pcs, r_regw, r_memw, r_valid;
    logic [1:0]         r_we;
    logic [3:0]         r_wd;
    logic [BANK_W-1:0]  r_wbank;
    logic [COUNT_W-1:0] r_fail;

    logic               w_fwd;
    logic [3:0]         w_base;
    logic [3:0]         w_eff;
    logic [1:0]         w_gen;
    logic [3:0]         w_wd;

    function automatic logic cond_pass(input logic [3:0] c, input logic [3:0] f);
        logic n, z, cf, v;
        {n, z, cf, v} = f;
        case (c)
            4'b0000: return z;
            4'b0001: return !z;
            4'b0010: return cf;
            4'b0011: return !cf;
            4'b0100: return n;
            4'b0101: return !n;
            4'b0110: return v;
            4'b0111: return !v;
            4'b1000: return cf && !z;
            4'b1001: return !cf || z;
            4'b1010: return n == v;
            4'b1011: return n != v;
            4'b1100: return !z && (n == v);
            4'b1101: return z || (n != v);
            default: return 1'b1;
        endcase
    endfunction

    // r_we is already gated by the M instruction's CondEx, so a non-zero group bit means a live pending write
    assign w_fwd   = (FWD_EN != 0) && (r_wbank == BankSel);
    assign w_base  = r_bank[BankSel];
    assign w_eff   = {(w_fwd && r_we[1]) ? r_wd[3:2] : w_base[3:2],
                      (w_fwd && r_we[0]) ? r_wd[1:0] : w_base[1:0]};
    assign CondExE = Valid && cond_pass(Cond, w_eff);
    assign w_gen   = FlagLoad ? 2'b11 : FlagW;
    assign w_wd    = FlagLoad ? FlagLoadData : ALUFlags;

    // The instruction leaving M commits unless a stall keeps it there; a flush replaces it, so it still leaves
    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int i = 0; i < NBANK; i++) r_bank[i] <= '0;
        end else if (!Stall || Flush) begin
            if (r_we[1]) r_bank[r_wbank][3:2] <= r_wd[3:2];
            if (r_we[0]) r_bank[r_wbank][1:0] <= r_wd[1:0];
        end
    end

    always_ff @(posedge CLK) begin
        if (RST || Flush) begin
            r_pcs   <= 1'b0;
            r_regw  <= 1'b0;
            r_memw  <= 1'b0;
            r_valid <= 1'b0;
            r_we    <= '0;
            r_wd    <= '0;
            r_wbank <= '0;
        end else if (!Stall) begin
            r_pcs   <= PCS && CondExE;
            r_regw  <= RegW && CondExE && !NoWrite;
            r_memw  <= MemW && CondExE;
            r_valid <= Valid;
            r_we    <= w_gen & {2{CondExE}};
            r_wd    <= w_wd;
            r_wbank <= BankSel;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST)
            r_fail <= '0;
        else if (Valid && !CondExE && !Stall && !Flush && !(&r_fail))
            r_fail <= r_fail + COUNT_W'(1);
    end

    assign PCSrcM    = r_pcs;
    assign RegWriteM = r_regw;
    assign MemWriteM = r_memw;
    assign ValidM    = r_valid;
    assign FlagsOut  = r_bank[BankSel];
    assign FailCount = r_fail;
endmodule

// File: tb/tb_condlogic_pipe.sv
// tb_condlogic_pipe: randomized and directed check of condlogic_pipe against a behavioural model
module tb_condlogic_pipe;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, valid, stall, flush, pcs, regw, memw, nowrite, fload, bsel;
    logic [1:0] flagw;
    logic [3:0] cond, alu, fdata;
    logic [2:0] ce, pcsm, regwm, memwm, validm;
    logic [3:0] fo0, fo1, fo2;
    logic [15:0] fc0, fc1;
    logic [1:0] fc2;

    condlogic_pipe #(.BANK_W(1), .FWD_EN(1), .COUNT_W(16)) dut (
        .CLK(clk), .RST(rst), .Valid(valid), .Stall(stall), .Flush(flush), .PCS(pcs), .RegW(regw),
        .MemW(memw), .NoWrite(nowrite), .FlagW(flagw), .Cond(cond), .ALUFlags(alu), .BankSel(bsel),
        .FlagLoad(fload), .FlagLoadData(fdata), .CondExE(ce[0]), .PCSrcM(pcsm[0]), .RegWriteM(regwm[0]),
        .MemWriteM(memwm[0]), .ValidM(validm[0]), .FlagsOut(fo0), .FailCount(fc0));

    condlogic_pipe #(.BANK_W(1), .FWD_EN(0), .COUNT_W(16)) dut_nf (
        .CLK(clk), .RST(rst), .Valid(valid), .Stall(stall), .Flush(flush), .PCS(pcs), .RegW(regw),
        .MemW(memw), .NoWrite(nowrite), .FlagW(flagw), .Cond(cond), .ALUFlags(alu), .BankSel(bsel),
        .FlagLoad(fload), .FlagLoadData(fdata), .CondExE(ce[1]), .PCSrcM(pcsm[1]), .RegWriteM(regwm[1]),
        .MemWriteM(memwm[1]), .ValidM(validm[1]), .FlagsOut(fo1), .FailCount(fc1));

    condlogic_pipe #(.BANK_W(1), .FWD_EN(1), .COUNT_W(2)) dut_c2 (
        .CLK(clk), .RST(rst), .Valid(valid), .Stall(stall), .Flush(flush), .PCS(pcs), .RegW(regw),
        .MemW(memw), .NoWrite(nowrite), .FlagW(flagw), .Cond(cond), .ALUFlags(alu), .BankSel(bsel),
        .FlagLoad(fload), .FlagLoadData(fdata), .CondExE(ce[2]), .PCSrcM(pcsm[2]), .RegWriteM(regwm[2]),
        .MemWriteM(memwm[2]), .ValidM(validm[2]), .FlagsOut(fo2), .FailCount(fc2));

    int n_cmp = 0;
    int n_err = 0;

    logic [3:0] mbank [3][2];
    logic       mpcs [3], mregw [3], mmemw [3], mvalid [3], mwb [3];
    logic [1:0] mwe [3];
    logic [3:0] mwd [3];
    int         mfail [3];
    int         mmax [3] = '{65535, 65535, 3};
    bit         mfwd [3] = '{1'b1, 1'b0, 1'b1};

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // ARM condition rule: even code tests a base predicate, odd code is its inverse, 111x always passes
    function automatic logic cond_ok(input logic [3:0] c, input logic [3:0] f);
        logic b;
        case (c[3:1])
            3'd0: b = f[2];
            3'd1: b = f[1];
            3'd2: b = f[3];
            3'd3: b = f[0];
            3'd4: b = f[1] && !f[2];
            3'd5: b = f[3] == f[0];
            3'd6: b = !f[2] && (f[3] == f[0]);
            default: return 1'b1;
        endcase
        return b ^ c[0];
    endfunction

    task automatic mreset(input int k);
        mbank[k][0] = 4'h0; mbank[k][1] = 4'h0;
        mpcs[k] = 0; mregw[k] = 0; mmemw[k] = 0; mvalid[k] = 0;
        mwe[k] = 0; mwd[k] = 0; mwb[k] = 0; mfail[k] = 0;
    endtask

    task automatic clr();
        rst = 0; valid = 0; stall = 0; flush = 0; pcs = 0; regw = 0; memw = 0; nowrite = 0;
        fload = 0; bsel = 0; flagw = 0; cond = 4'he; alu = 0; fdata = 0;
    endtask

    task automatic step();
        logic [3:0] eff;
        logic p;
        #1;
        for (int k = 0; k < 3; k++) begin
            eff = mbank[k][bsel];
            if (mfwd[k] && mwb[k] == bsel) begin
                if (mwe[k][1]) eff[3:2] = mwd[k][3:2];
                if (mwe[k][0]) eff[1:0] = mwd[k][1:0];
            end
            p = valid && cond_ok(cond, eff);
            chk($sformatf("condex%0d", k), ce[k], p);
            chk($sformatf("flags%0d", k), k == 0 ? fo0 : k == 1 ? fo1 : fo2, mbank[k][bsel]);
            chk($sformatf("pcsm%0d", k), pcsm[k], mpcs[k]);
            chk($sformatf("regwm%0d", k), regwm[k], mregw[k]);
            chk($sformatf("memwm%0d", k), memwm[k], mmemw[k]);
            chk($sformatf("validm%0d", k), validm[k], mvalid[k]);
            chk($sformatf("failcnt%0d", k), k == 0 ? 32'(fc0) : k == 1 ? 32'(fc1) : 32'(fc2), mfail[k]);
            if (rst) mreset(k);
            else begin
                if (!stall || flush) begin
                    if (mwe[k][1]) mbank[k][mwb[k]][3:2] = mwd[k][3:2];
                    if (mwe[k][0]) mbank[k][mwb[k]][1:0] = mwd[k][1:0];
                end
                if (valid && !p && !stall && !flush && mfail[k] < mmax[k]) mfail[k]++;
                if (flush) begin
                    mpcs[k] = 0; mregw[k] = 0; mmemw[k] = 0; mvalid[k] = 0; mwe[k] = 0; mwd[k] = 0; mwb[k] = 0;
                end else if (!stall) begin
                    mpcs[k] = pcs && p;
                    mregw[k] = regw && p && !nowrite;
                    mmemw[k] = memw && p;
                    mvalid[k] = valid;
                    mwe[k] = p ? (fload ? 2'b11 : flagw) : 2'b00;
                    mwd[k] = fload ? fdata : alu;
                    mwb[k] = bsel;
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        clr();
        rst = 1;
        repeat (2) @(posedge clk);
        #1;
        for (int k = 0; k < 3; k++) mreset(k);
        step();
        rst = 0;
        clr(); valid = 1; regw = 1; cond = 4'b0000;
        #1 chk("eq_ce", ce[0], 0);
        step();
        chk("eq_cnt", fc0, 1); chk("eq_validm", validm[0], 1); chk("eq_regwm", regwm[0], 0);
        clr(); valid = 1; regw = 1; nowrite = 1; flagw = 2'b11; alu = 4'b0100;
        step();
        clr(); valid = 1; pcs = 1; cond = 4'b0000;
        #1 chk("fwd_ce", ce[0], 1); chk("nofwd_ce", ce[1], 0);
        step();
        chk("fwd_pcsm", pcsm[0], 1); chk("nofwd_pcsm", pcsm[1], 0);
        clr(); valid = 1; fload = 1; fdata = 4'b1000;
        step();
        clr(); valid = 1; flagw = 2'b01; alu = 4'b0010;
        step();
        clr(); valid = 1; cond = 4'b0100;
        #1 chk("mi_ce", ce[0], 1); chk("mi_bank", fo0, 4'b1000);
        step();
        clr(); valid = 1; cond = 4'b0010;
        #1 chk("cs_ce", ce[0], 1);
        step();
        clr(); valid = 1; fload = 1; fdata = 4'b0110;
        step();
        clr(); stall = 1; valid = 1; cond = 4'b0100;
        repeat (3) step();
        chk("stall_flags", fo0, 4'b1010); chk("stall_validm", validm[0], 1);
        clr();
        step();
        chk("stall_commit", fo0, 4'b0110);
        clr(); valid = 1; flagw = 2'b11; alu = 4'b1001;
        step();
        clr(); stall = 1; flush = 1; valid = 1;
        step();
        chk("fs_validm", validm[0], 0); chk("fs_commit", fo0, 4'b1001);
        clr(); rst = 1;
        step();
        clr(); valid = 1; fload = 1; fdata = 4'hf; bsel = 1;
        step();
        clr();
        step();
        bsel = 1;
        #1 chk("bank1", fo0, 4'hf);
        bsel = 0;
        #1 chk("bank0", fo0, 4'h0);
        clr(); rst = 1;
        step();
        clr(); valid = 1; cond = 4'b0000;
        repeat (5) step();
        chk("sat2", fc2, 2'd3); chk("cnt16", fc0, 5);
        clr(); valid = 1; fload = 1; fdata = 4'hf;
        step();
        clr(); rst = 1;
        step();
        clr();
        step();
        chk("rst_nocommit", fo0, 4'h0);
        repeat (400) begin
            rst = ($urandom_range(0, 49) == 0);
            valid = ($urandom_range(0, 3) != 0);
            stall = ($urandom_range(0, 4) == 0);
            flush = ($urandom_range(0, 7) == 0);
            pcs = 1'($urandom); regw = 1'($urandom); memw = 1'($urandom); nowrite = 1'($urandom);
            fload = ($urandom_range(0, 5) == 0);
            bsel = 1'($urandom); flagw = 2'($urandom);
            cond = 4'($urandom); alu = 4'($urandom); fdata = 4'($urandom);
            step();
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
